// File: rtl/edf_ic_pkg.sv
// Shared constants and types for the EDF interrupt controller.
package edf_ic_pkg;

    localparam int unsigned NSource = 8;
    localparam int unsigned TsWidth = 64;
    localparam int unsigned IdWidth = $clog2(NSource);

    typedef logic [TsWidth-1:0] deadline_t;
    typedef logic [IdWidth-1:0] src_id_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        PUBLISH
    } arb_state_e;

endpackage

// File: rtl/edf_min_step.sv
// One compare/update step of the running earliest-deadline minimum.
module edf_min_step
    import edf_ic_pkg::*;
(
    input  logic               best_valid_i,
    input  logic [IdWidth-1:0] best_id_i,
    input  logic [TsWidth-1:0] best_dl_i,
    input  logic               cand_ip_i,
    input  logic [IdWidth-1:0] cand_id_i,
    input  logic [TsWidth-1:0] cand_dl_i,
    output logic               upd_valid_c,
    output logic [IdWidth-1:0] upd_id_c,
    output logic [TsWidth-1:0] upd_dl_c
);

    logic take;

    // Strict less-than keeps the earlier (lower) index on equal deadlines.
    assign take        = cand_ip_i & (~best_valid_i | (cand_dl_i < best_dl_i));
    assign upd_valid_c = take | best_valid_i;
    assign upd_id_c    = take ? cand_id_i : best_id_i;
    assign upd_dl_c    = take ? cand_dl_i : best_dl_i;

endmodule

// File: rtl/edf_arbiter.sv
// Serial earliest-deadline-first selector: scans all sources, publishes the
// pending one with the smallest deadline and returns a one-hot claim pulse.
module edf_arbiter
    import edf_ic_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic [NSource-1:0]         ip_i,
    input  logic [NSource*TsWidth-1:0] dl_i,
    input  logic                       claim_i,
    output logic                       irq_o,
    output logic [IdWidth-1:0]         irq_id_o,
    output logic [TsWidth-1:0]         irq_dl_o,
    output logic [NSource-1:0]         claim_o
);

    arb_state_e         state_q, state_d;
    src_id_t            idx_q, idx_d;
    logic               best_valid_q, best_valid_d;
    src_id_t            best_id_q, best_id_d;
    deadline_t          best_dl_q, best_dl_d;
    logic               irq_q, irq_d;
    src_id_t            irq_id_q, irq_id_d;
    deadline_t          irq_dl_q, irq_dl_d;
    logic [NSource-1:0] claim_q, claim_d;

    deadline_t          cand_dl;
    logic               step_valid;
    src_id_t            step_id;
    deadline_t          step_dl;
    logic               go;

    assign cand_dl = dl_i[int'(idx_q)*TsWidth +: TsWidth];
    assign go      = enable_i & (|ip_i);

    edf_min_step u_step (
        .best_valid_i (best_valid_q),
        .best_id_i    (best_id_q),
        .best_dl_i    (best_dl_q),
        .cand_ip_i    (ip_i[idx_q]),
        .cand_id_i    (idx_q),
        .cand_dl_i    (cand_dl),
        .upd_valid_c  (step_valid),
        .upd_id_c     (step_id),
        .upd_dl_c     (step_dl)
    );

    // Next-state and registered-output logic; later overrides take priority.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        best_valid_d = best_valid_q;
        best_id_d    = best_id_q;
        best_dl_d    = best_dl_q;
        irq_d        = irq_q;
        irq_id_d     = irq_id_q;
        irq_dl_d     = irq_dl_q;
        claim_d      = '0;

        if (irq_q && !ip_i[irq_id_q]) begin
            irq_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                idx_d        = '0;
                best_valid_d = 1'b0;
                if (go) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                best_valid_d = step_valid;
                best_id_d    = step_id;
                best_dl_d    = step_dl;
                if (idx_q == IdWidth'(NSource - 1)) begin
                    idx_d   = '0;
                    state_d = PUBLISH;
                end else begin
                    idx_d = idx_q + IdWidth'(1);
                end
            end
            PUBLISH: begin
                if (best_valid_q) begin
                    irq_d    = 1'b1;
                    irq_id_d = best_id_q;
                    irq_dl_d = best_dl_q;
                end else begin
                    irq_d = 1'b0;
                end
                best_valid_d = 1'b0;
                best_id_d    = '0;
                best_dl_d    = '0;
                idx_d        = '0;
                state_d      = go ? SCAN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A claim or a disable aborts the scan and discards any publish.
        if ((enable_i && claim_i && irq_q) || !enable_i) begin
            if (enable_i) begin
                claim_d = NSource'(1) << irq_id_q;
            end
            irq_d        = 1'b0;
            irq_id_d     = irq_id_q;
            irq_dl_d     = irq_dl_q;
            state_d      = IDLE;
            idx_d        = '0;
            best_valid_d = 1'b0;
            best_id_d    = '0;
            best_dl_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            best_valid_q <= 1'b0;
            best_id_q    <= '0;
            best_dl_q    <= '0;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            irq_dl_q     <= '0;
            claim_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            best_valid_q <= best_valid_d;
            best_id_q    <= best_id_d;
            best_dl_q    <= best_dl_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
            irq_dl_q     <= irq_dl_d;
            claim_q      <= claim_d;
        end
    end

    assign irq_o    = irq_q;
    assign irq_id_o = irq_id_q;
    assign irq_dl_o = irq_dl_q;
    assign claim_o  = claim_q;

endmodule

// File: tb/tb_edf_arbiter.sv
// Directed bench for edf_arbiter with a sample-then-select reference model
// compared on every falling edge.
module tb_edf_arbiter;
    import edf_ic_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_ni = 1'b0;
    logic                       en = 1'b0;
    logic [NSource-1:0]         ip = '0;
    logic [NSource*TsWidth-1:0] dl = '0;
    logic                       claim = 1'b0;
    logic                       irq_o;
    logic [IdWidth-1:0]         irq_id_o;
    logic [TsWidth-1:0]         irq_dl_o;
    logic [NSource-1:0]         claim_o;

    int n_vec  = 0;
    int n_fail = 0;

    edf_arbiter dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .enable_i (en),
        .ip_i     (ip),
        .dl_i     (dl),
        .claim_i  (claim),
        .irq_o    (irq_o),
        .irq_id_o (irq_id_o),
        .irq_dl_o (irq_dl_o),
        .claim_o  (claim_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pos -1 = idle, 0..N-1 = sampling source pos, N = publish.
    int                 m_pos = -1;
    logic               m_sip [NSource];
    logic [TsWidth-1:0] m_sdl [NSource];
    logic               m_irq = 1'b0;
    logic [IdWidth-1:0] m_id = '0;
    logic [TsWidth-1:0] m_dl = '0;
    logic [NSource-1:0] m_claim = '0;

    task automatic clear_samples();
        for (int k = 0; k < int'(NSource); k++) begin
            m_sip[k] = 1'b0;
            m_sdl[k] = '0;
        end
    endtask

    // Smallest pending deadline first, then the lowest index carrying it.
    task automatic find_winner(output logic found, output int wid, output logic [TsWidth-1:0] wdl);
        found = 1'b0;
        wdl   = '1;
        wid   = 0;
        for (int k = 0; k < int'(NSource); k++) begin
            if (m_sip[k]) begin
                found = 1'b1;
                if (m_sdl[k] < wdl) wdl = m_sdl[k];
            end
        end
        for (int k = int'(NSource) - 1; k >= 0; k--) begin
            if (m_sip[k] && m_sdl[k] == wdl) wid = k;
        end
    endtask

    initial begin
        logic               n_irq, found;
        logic [IdWidth-1:0] n_id;
        logic [TsWidth-1:0] n_dl, wdl;
        logic [NSource-1:0] n_claim;
        int                 n_pos, wid;
        bit                 go;
        clear_samples();
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) begin
                m_pos = -1; m_irq = 1'b0; m_id = '0; m_dl = '0; m_claim = '0;
                clear_samples();
            end else begin
                go = en && (|ip);
                n_irq = m_irq; n_id = m_id; n_dl = m_dl; n_claim = '0; n_pos = m_pos;
                if (m_irq && !ip[m_id]) n_irq = 1'b0;
                if (m_pos < 0) begin
                    if (go) n_pos = 0;
                end else if (m_pos < int'(NSource)) begin
                    m_sip[m_pos] = ip[m_pos];
                    m_sdl[m_pos] = dl[m_pos*TsWidth +: TsWidth];
                    n_pos = m_pos + 1;
                end else begin
                    find_winner(found, wid, wdl);
                    if (found) begin
                        n_irq = 1'b1; n_id = IdWidth'(wid); n_dl = wdl;
                    end else begin
                        n_irq = 1'b0;
                    end
                    clear_samples();
                    n_pos = go ? 0 : -1;
                end
                if (!en || (claim && m_irq)) begin
                    if (en) n_claim = NSource'(1) << m_id;
                    n_irq = 1'b0; n_id = m_id; n_dl = m_dl; n_pos = -1;
                    clear_samples();
                end
                m_pos = n_pos; m_irq = n_irq; m_id = n_id; m_dl = n_dl; m_claim = n_claim;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_irq", 64'(irq_o), 64'(m_irq));
            chk("model_id", 64'(irq_id_o), 64'(m_id));
            chk("model_dl", irq_dl_o, m_dl);
            chk("model_claim", 64'(claim_o), 64'(m_claim));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_dl(input int k, input logic [TsWidth-1:0] v);
        dl[k*TsWidth +: TsWidth] = v;
    endtask

    task automatic wait_irq(input int budget, input string name);
        int c = 0;
        while (irq_o !== 1'b1 && c < budget) begin
            tick(1);
            c++;
        end
        chk(name, 64'(irq_o), 64'd1);
    endtask

    task automatic idle_out();
        ip = '0;
        claim = 1'b0;
        tick(12);
    endtask

    initial begin
        tick(3);
        chk("reset_irq", 64'(irq_o), 64'd0);
        chk("reset_id", 64'(irq_id_o), 64'd0);
        chk("reset_dl", irq_dl_o, 64'd0);
        chk("reset_claim", 64'(claim_o), 64'd0);
        rst_ni = 1'b1; en = 1'b1;
        tick(2);

        // Single source, entry latency and claim pulse
        set_dl(3, 64'd100); ip[3] = 1'b1;
        tick(9);
        chk("t1_early_irq", 64'(irq_o), 64'd0);
        tick(1);
        chk("t1_irq", 64'(irq_o), 64'd1);
        chk("t1_id", 64'(irq_id_o), 64'd3);
        chk("t1_dl", irq_dl_o, 64'd100);
        claim = 1'b1;
        tick(1);
        chk("t1_claim", 64'(claim_o), 64'h08);
        chk("t1_claim_irq", 64'(irq_o), 64'd0);
        claim = 1'b0; ip[3] = 1'b0;
        tick(1);
        chk("t1_claim_end", 64'(claim_o), 64'd0);
        claim = 1'b1;
        tick(1);
        chk("t1_stray_claim", 64'(claim_o), 64'd0);
        idle_out();

        // EDF ordering
        set_dl(1, 64'd500); set_dl(5, 64'd200); set_dl(6, 64'd300);
        ip = 8'b0110_0010;
        tick(10);
        chk("t2_id", 64'(irq_id_o), 64'd5);
        chk("t2_dl", irq_dl_o, 64'd200);
        claim = 1'b1;
        tick(1);
        chk("t2_claim", 64'(claim_o), 64'h20);
        claim = 1'b0; ip[5] = 1'b0;
        wait_irq(25, "t2_second_irq");
        chk("t2_second_id", 64'(irq_id_o), 64'd6);
        chk("t2_second_dl", irq_dl_o, 64'd300);
        idle_out();

        // Equal deadlines: lower index wins
        set_dl(2, 64'd42); set_dl(7, 64'd42);
        ip = 8'b1000_0100;
        tick(10);
        chk("t3_id", 64'(irq_id_o), 64'd2);
        chk("t3_dl", irq_dl_o, 64'd42);
        ip[2] = 1'b0;
        tick(1);
        chk("t3_inval_irq", 64'(irq_o), 64'd0);
        wait_irq(25, "t3_second_irq");
        chk("t3_second_id", 64'(irq_id_o), 64'd7);
        idle_out();

        // Arrival while the scan is at index 4
        set_dl(0, 64'd900); ip[0] = 1'b1;
        tick(5);
        set_dl(1, 64'd10); ip[1] = 1'b1;
        tick(5);
        chk("t4_first_id", 64'(irq_id_o), 64'd0);
        chk("t4_first_dl", irq_dl_o, 64'd900);
        tick(9);
        chk("t4_second_irq", 64'(irq_o), 64'd1);
        chk("t4_second_id", 64'(irq_id_o), 64'd1);
        chk("t4_second_dl", irq_dl_o, 64'd10);
        idle_out();

        // Invalidation and disable
        set_dl(4, 64'd77); ip[4] = 1'b1;
        tick(10);
        chk("t5_id", 64'(irq_id_o), 64'd4);
        ip[4] = 1'b0;
        tick(1);
        chk("t5_inval_irq", 64'(irq_o), 64'd0);
        chk("t5_inval_claim", 64'(claim_o), 64'd0);
        ip[4] = 1'b1;
        wait_irq(25, "t5_repub_irq");
        tick(3);
        en = 1'b0; claim = 1'b1;
        tick(1);
        chk("t5_dis_irq", 64'(irq_o), 64'd0);
        chk("t5_dis_claim", 64'(claim_o), 64'd0);
        tick(1);
        chk("t5_dis_claim2", 64'(claim_o), 64'd0);
        claim = 1'b0; en = 1'b1;
        tick(10);
        chk("t5_reen_irq", 64'(irq_o), 64'd1);
        chk("t5_reen_id", 64'(irq_id_o), 64'd4);

        // Asynchronous reset mid-scan with a published winner
        tick(3);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_rst_irq", 64'(irq_o), 64'd0);
        chk("t6_rst_id", 64'(irq_id_o), 64'd0);
        chk("t6_rst_dl", irq_dl_o, 64'd0);
        chk("t6_rst_claim", 64'(claim_o), 64'd0);
        tick(1);
        rst_ni = 1'b1;
        tick(9);
        chk("t6_early_irq", 64'(irq_o), 64'd0);
        tick(1);
        chk("t6_irq", 64'(irq_o), 64'd1);
        chk("t6_id", 64'(irq_id_o), 64'd4);
        chk("t6_dl", irq_dl_o, 64'd77);

        ip = '0; en = 1'b0;
        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_fail);
        $fatal(1);
    end

endmodule
